// File: rtl/cnn_pkg.sv
// Shared fixed-point constants, layout helpers and the saturating
// shift used by the CNN datapath blocks (and the weight-ROM generator).
package cnn_pkg;
   localparam int CNN_BITWIDTH = 16;
   localparam int CNN_FRAC     = 8;
   localparam int CNN_IN_LEN   = 48;
   localparam int CNN_OUT_LEN  = 10;
   localparam int SAT_W        = 64;

   typedef enum logic [1:0] {FC_IDLE, FC_RUN, FC_FLUSH, FC_DONE} fc_state_e;

   // Never returns less than 1 so single-entry counters still get a bit.
   function automatic int cnn_clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      if (r < 1) r = 1;
      return r;
   endfunction

   // Word address of element i (i == in_len is the bias) of neuron n.
   function automatic int wmem_index(input int n, input int i, input int in_len);
      return n * (in_len + 1) + i;
   endfunction

   function automatic logic signed [SAT_W-1:0] sat_shift(
      input logic signed [SAT_W-1:0] acc,
      input int                      frac,
      input int                      bw);
      logic signed [SAT_W-1:0] sh;
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      sh = acc >>> frac;
      hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (sh > hi) return hi;
      if (sh < lo) return lo;
      return sh;
   endfunction
endpackage

// File: rtl/fc_layer_if.sv
// Synchronous weight-memory read port: the layer drives address/strobe,
// the memory returns data one cycle later and holds it until the next strobe.
interface fc_layer_if #(
   parameter int AW       = 4,
   parameter int BITWIDTH = 16
);
   logic [AW-1:0]              weight_addr;
   logic                       weight_rd_en;
   logic signed [BITWIDTH-1:0] weight_in;

   modport master (output weight_addr, output weight_rd_en, input weight_in);
   modport slave  (input weight_addr, input weight_rd_en, output weight_in);
endinterface

// File: rtl/fc_mac.sv
// Time-multiplexed signed MAC: accumulates w*x, folds in the aligned bias and
// presents the saturated (optionally ReLU'd) neuron result on the bias word.
module fc_mac
   import cnn_pkg::*;
#(
   parameter int BITWIDTH = CNN_BITWIDTH,
   parameter int FRAC     = CNN_FRAC,
   parameter int ACCWIDTH = 40,
   parameter int RELU     = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clken,
   input  logic                       consume,
   input  logic                       is_bias,
   input  logic signed [BITWIDTH-1:0] x,
   input  logic signed [BITWIDTH-1:0] w,
   output logic signed [BITWIDTH-1:0] result
);
   logic signed [ACCWIDTH-1:0]   acc_q, acc_d;
   logic signed [ACCWIDTH-1:0]   prod_ext, bias_al, total;
   logic signed [2*BITWIDTH-1:0] prod;

   always_comb begin
      prod     = x * w;
      prod_ext = ACCWIDTH'(prod);
      bias_al  = ACCWIDTH'(w) <<< FRAC;
      total    = acc_q + bias_al;
      acc_d    = acc_q;
      // Clearing on the bias word lets the next neuron start with no bubble.
      if (consume) acc_d = is_bias ? '0 : acc_q + prod_ext;
      result = BITWIDTH'(sat_shift(SAT_W'(total), FRAC, BITWIDTH));
      if (RELU != 0 && result < 0) result = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     acc_q <= '0;
      else if (clken) acc_q <= acc_d;
   end
endmodule

// File: rtl/fc_layer.sv
// Dense layer: latches the pooled vector, streams OUT_LEN*(IN_LEN+1) weight
// words through one MAC and collects the neuron results in a register file.
module fc_layer
   import cnn_pkg::*;
#(
   parameter int BITWIDTH = CNN_BITWIDTH,
   parameter int FRAC     = CNN_FRAC,
   parameter int IN_LEN   = CNN_IN_LEN,
   parameter int OUT_LEN  = CNN_OUT_LEN,
   parameter int ACCWIDTH = 40,
   parameter int RELU     = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clken,
   input  logic [BITWIDTH*IN_LEN-1:0]   data_in,
   input  logic                         data_valid_in,
   fc_layer_if.master                   wmem,
   output logic [BITWIDTH*OUT_LEN-1:0]  result_out,
   output logic                         result_valid_out,
   output logic                         busy
);
   localparam int WORDS = OUT_LEN * (IN_LEN + 1);
   localparam int AW    = cnn_clog2(WORDS);
   localparam int IW    = cnn_clog2(IN_LEN + 1);
   localparam int NW    = cnn_clog2(OUT_LEN);

   fc_state_e                    state_q, state_d;
   logic                         dv_prev_q;
   logic [AW-1:0]                addr_q, addr_d;
   logic [IW-1:0]                i_q, i_d, ci_q, ci_d;
   logic [NW-1:0]                n_q, n_d, cn_q, cn_d;
   logic                         pend_q, pend_d;
   logic signed [BITWIDTH-1:0]   x_q [IN_LEN];
   logic signed [BITWIDTH-1:0]   x_d [IN_LEN];
   logic [BITWIDTH*OUT_LEN-1:0]  res_q, res_d;
   logic                         accept, issue, last_issue, is_bias;
   logic signed [BITWIDTH-1:0]   x_sel, mac_res;

   assign accept     = (state_q == FC_IDLE) && data_valid_in && !dv_prev_q;
   assign issue      = (state_q == FC_RUN);
   assign last_issue = (addr_q == AW'(WORDS - 1));
   assign is_bias    = (ci_q == IW'(IN_LEN));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     state_q <= FC_IDLE;
      else if (clken) state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FC_IDLE:  if (accept) state_d = FC_RUN;
         FC_RUN:   if (last_issue) state_d = FC_FLUSH;
         FC_FLUSH: state_d = FC_DONE;
         FC_DONE:  state_d = FC_IDLE;
         default:  state_d = FC_IDLE;
      endcase
   end

   // The strobe is gated by clken so a stalled cycle never advances the memory.
   always_comb begin
      wmem.weight_rd_en = issue && clken;
      wmem.weight_addr  = addr_q;
      busy              = (state_q != FC_IDLE);
      result_valid_out  = (state_q == FC_DONE);
      result_out        = res_q;
   end

   always_comb begin
      addr_d = addr_q;
      i_d    = i_q;
      n_d    = n_q;
      if (issue) begin
         if (last_issue) begin
            addr_d = '0;
            i_d    = '0;
            n_d    = '0;
         end else begin
            addr_d = addr_q + AW'(1);
            if (i_q == IW'(IN_LEN)) begin
               i_d = '0;
               n_d = n_q + NW'(1);
            end else begin
               i_d = i_q + IW'(1);
            end
         end
      end
      // Consume-side copies line up with the word the memory returns next cycle.
      pend_d = issue;
      ci_d   = i_q;
      cn_d   = n_q;
      x_d    = x_q;
      if (accept)
         for (int k = 0; k < IN_LEN; k++) x_d[k] = data_in[k*BITWIDTH +: BITWIDTH];
      x_sel = '0;
      for (int k = 0; k < IN_LEN; k++)
         if (ci_q == IW'(k)) x_sel = x_q[k];
      res_d = res_q;
      if (pend_q && is_bias)
         for (int k = 0; k < OUT_LEN; k++)
            if (cn_q == NW'(k)) res_d[k*BITWIDTH +: BITWIDTH] = mac_res;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dv_prev_q <= 1'b0;
         addr_q    <= '0;
         i_q       <= '0;
         n_q       <= '0;
         ci_q      <= '0;
         cn_q      <= '0;
         pend_q    <= 1'b0;
         res_q     <= '0;
      end else if (clken) begin
         dv_prev_q <= data_valid_in;
         addr_q    <= addr_d;
         i_q       <= i_d;
         n_q       <= n_d;
         ci_q      <= ci_d;
         cn_q      <= cn_d;
         pend_q    <= pend_d;
         res_q     <= res_d;
      end
   end

   always_ff @(posedge clk) begin
      if (clken) x_q <= x_d;
   end

   fc_mac #(
      .BITWIDTH (BITWIDTH),
      .FRAC     (FRAC),
      .ACCWIDTH (ACCWIDTH),
      .RELU     (RELU)
   ) u_mac (
      .clk     (clk),
      .rst_n   (rst_n),
      .clken   (clken),
      .consume (pend_q),
      .is_bias (is_bias),
      .x       (x_sel),
      .w       (wmem.weight_in),
      .result  (mac_res)
   );
endmodule

// File: doc/fc_layer.md
# fc_layer

Fully connected (dense) layer that consumes the flattened feature vector from the max-pooling stage and produces `OUT_LEN` neuron outputs. It uses a single time-multiplexed signed MAC. Weights and biases are streamed from an external synchronous weight memory. It sits directly downstream of the pooling stage: its `data_in` and `data_valid_in` connect to the pool's `result_out` and `result_valid_out`.

## Interface
- `BITWIDTH`, 16: data, weight and result word width; signed two's complement, Q(BITWIDTH-FRAC).FRAC.
- `FRAC`, 8: fractional bits.
- `IN_LEN`, 48: input vector length (4×4×3 pooled map).
- `OUT_LEN`, 10: number of neurons.
- `ACCWIDTH`, 40: accumulator width; must be ≥ 2·BITWIDTH + clog2(IN_LEN+1).
- `RELU`, 1: 1 = clamp negative results to 0; 0 = pass signed results.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `clken`  in  1  global enable; when 0, all state is frozen.
- `data_in`  in  BITWIDTH·IN_LEN  flattened input; element i is at `[i*BITWIDTH +: BITWIDTH]`.
- `data_valid_in`  in  1  input-ready flag from the pool stage.
- `weight_addr`  out  clog2(OUT_LEN·(IN_LEN+1))  weight memory address.
- `weight_rd_en`  out  1  weight memory read strobe.
- `weight_in`  in  BITWIDTH  weight memory read data; valid one cycle after the strobe. The memory holds its output until the next strobe.
- `result_out`  out  BITWIDTH·OUT_LEN  neuron n is at `[n*BITWIDTH +: BITWIDTH]`.
- `result_valid_out`  out  1  one-cycle pulse when all outputs are fresh.
- `busy`  out  1  high from acceptance until the `result_valid_out` cycle, inclusive.

## Operation
- **Memory layout:** neuron n occupies words n·(IN_LEN+1)+i. Word i = 0..IN_LEN-1 is the weight for input i; word IN_LEN is the bias.
- **Acceptance:** an input is accepted on a 0→1 transition of `data_valid_in`, sampled on clken cycles, while in IDLE.
  - The whole `data_in` is latched internally on the acceptance cycle.
  - Edges seen while busy are ignored and not queued.
  - A level held high after completion does not retrigger.
- **States:**
  - IDLE → (accept) → RUN.
  - RUN issues sequential reads 0 … OUT_LEN·(IN_LEN+1)−1, one per clken cycle.
  - RUN → (last read issued) → FLUSH.
  - FLUSH consumes the final data word → DONE.
  - DONE pulses `result_valid_out` → IDLE.
- **MAC:** each returned weight word w_i is multiplied by latched input x_i (full 2·BITWIDTH signed product) and added to the accumulator.
  - The bias word is sign-extended and shifted left by FRAC before being added.
  - The accumulator clears when neuron n's bias is consumed, so neuron n+1 starts from 0 with no bubble.
- **Output conversion:** acc >>> FRAC (arithmetic shift), then saturate to [−2^(BITWIDTH−1), 2^(BITWIDTH−1)−1], then apply ReLU if `RELU`=1.
  - The result is written to slot n in the same cycle the bias is consumed.
  - Other slots hold their previous values.
- **Stall:** when `clken`=0, counters, the accumulator, the FSM and outputs hold. `weight_rd_en` is forced to 0. The read pipeline resumes losslessly because the memory holds its output.

## Timing
- **Reset values:** `result_out`=0, `result_valid_out`=0, `weight_rd_en`=0, `weight_addr`=0, `busy`=0, FSM in IDLE, accumulator=0.
- **Reset mid-operation:** abort immediately. All outputs return to their reset values and no valid pulse is produced.
- **Read window:** with acceptance at clken-cycle 0, `weight_rd_en`=1 on clken-cycles 1 … OUT_LEN·(IN_LEN+1), with `weight_addr` = cycle−1.
- **Valid pulse:** `result_valid_out` is 1 on clken-cycle OUT_LEN·(IN_LEN+1)+2 only.
- **Latency:** total latency is OUT_LEN·(IN_LEN+1)+2 clken cycles; 492 cycles at defaults.
- **Re-acceptance:** the earliest re-acceptance is the clken cycle after the valid pulse, provided a fresh 0→1 edge appears.

## Structure
- **Shared package `cnn_pkg`:**
  - fixed-point constants (BITWIDTH, FRAC);
  - a saturate-and-shift function;
  - a clog2 function;
  - memory-layout index constants, shared with the weight-ROM generator.
- **Sub-module `fc_mac`:** signed multiply, accumulate, bias alignment, clear, and the saturate/ReLU output stage.
- **Top level:** the FSM, address counter, input latch and result register file.

## Test plan
Bench parameters: IN_LEN=4, OUT_LEN=2, FRAC=8, BITWIDTH=16.
- **Basic:** inputs all 0x0100, weights 0x0100, biases 0 and 0x0080 → `result_out` = {0x0480, 0x0400}. Valid pulse at cycle 12; `weight_addr` sequence 0..9 on cycles 1..10.
- **Saturation / ReLU:** inputs 0x7FFF, weights 0x7FFF → 0x7FFF. Weights 0x8000 with RELU=0 → 0x8000; with RELU=1 → 0x0000.
- **clken stall:** clken low for 3 cycles mid-neuron 0 and 2 cycles during FLUSH → same results as Basic, valid at clken-cycle 12, `weight_rd_en` low during the stalls.
- **Edge/busy:** second `data_valid_in` edge at cycle 5 → ignored, exactly one valid pulse. Holding `data_valid_in` high for 30 cycles → exactly one run.
- **Reset:** `rst_n` low at cycle 6 → all outputs 0 immediately, no valid pulse. A new edge after release → correct full run.
